// File: rtl/eth_tx_sched_pkg.sv
// Shared state encoding and protocol constants for the Ethernet transmit scheduler.
package eth_tx_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PAD,
    KICK,
    WAIT_TX,
    TX,
    IFG
  } eth_tx_sched_state_t;

  localparam int pMIN_PAYLOAD = 46;
  localparam int pIFG_DEFAULT = 48;

endpackage

// File: rtl/eth_tx_sched_arb.sv
// Round-robin arbiter: combinational one-hot pick starting at the pointer,
// pointer moves past the winner whenever the caller accepts the grant.
module rr_arbiter
  import eth_tx_sched_pkg::*;
#(
  parameter int pNUM_SRC = 2
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic [pNUM_SRC-1:0] Req,
  input  logic                Advance,
  output logic [pNUM_SRC-1:0] Gnt,
  output logic                Gnt_Valid
);

  localparam int PW = (pNUM_SRC > 1) ? $clog2(pNUM_SRC) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_win;

  always_comb begin
    int idx;
    Gnt       = '0;
    Gnt_Valid = 1'b0;
    w_win     = '0;
    idx       = 0;
    for (int k = 0; k < pNUM_SRC; k++) begin
      idx = (int'(r_ptr) + k) % pNUM_SRC;
      if (!Gnt_Valid && Req[idx]) begin
        Gnt_Valid = 1'b1;
        Gnt[idx]  = 1'b1;
        w_win     = PW'(idx);
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ptr <= '0;
    end else if (Advance && Gnt_Valid) begin
      r_ptr <= (w_win == PW'(pNUM_SRC - 1)) ? '0 : w_win + 1'b1;
    end
  end

endmodule

// File: rtl/eth_tx_sched.sv
// Round-robin packet scheduler feeding the RMII tx FIFO and pacing frames by Tx_En + IFG.
// Optional zero padding to the minimum payload is enabled with `define ETH_TX_SCHED_PAD_EN.
module eth_tx_sched
  import eth_tx_sched_pkg::*;
#(
  parameter int pNUM_SRC     = 2,
  parameter int pMAX_PAYLOAD = 1500,
  parameter int pIFG_CYCLES  = pIFG_DEFAULT
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [pNUM_SRC-1:0]   Src_Req,
  input  logic [8*pNUM_SRC-1:0] Src_Byte,
  input  logic [pNUM_SRC-1:0]   Src_Valid,
  input  logic [pNUM_SRC-1:0]   Src_Last,
  output logic [pNUM_SRC-1:0]   Src_Ready,
  output logic [pNUM_SRC-1:0]   Src_Gnt,
  output logic [pNUM_SRC-1:0]   Src_Done,
  output logic [7:0]            Eth_Byte,
  output logic                  Eth_Byte_Valid,
  output logic                  Eth_Pkt_Rdy,
  input  logic                  Tx_En,
  output logic                  Busy,
  output logic                  Len_Err
);

  localparam int CW = 11;
  localparam int IW = $clog2(pIFG_CYCLES + 1);

  eth_tx_sched_state_t r_state;
  logic [pNUM_SRC-1:0] r_gnt;
  logic [CW-1:0]       r_cnt;
  logic                r_drop;
  logic [IW-1:0]       r_ifg;
  logic [7:0]          r_byte;
  logic                r_byte_vld;
  logic                r_pkt_rdy;
  logic                r_len_err;

  logic [pNUM_SRC-1:0] w_arb_gnt;
  logic                w_arb_vld;
  logic                w_adv;
  logic                w_xfer;
  logic                w_last;
  logic                w_room;
  logic [7:0]          w_sel_byte;

  assign w_adv = (r_state == IDLE);

  rr_arbiter #(.pNUM_SRC(pNUM_SRC)) u_arb (
    .Clk       (Clk),
    .Rst       (Rst),
    .Req       (Src_Req),
    .Advance   (w_adv),
    .Gnt       (w_arb_gnt),
    .Gnt_Valid (w_arb_vld)
  );

  always_comb begin
    w_sel_byte = '0;
    w_last     = 1'b0;
    for (int k = 0; k < pNUM_SRC; k++) begin
      if (r_gnt[k]) begin
        w_sel_byte = Src_Byte[8*k +: 8];
        w_last     = Src_Last[k];
      end
    end
  end

  assign w_xfer = (r_state == LOAD) && |(Src_Valid & r_gnt);
  assign w_room = (r_cnt < CW'(pMAX_PAYLOAD));

`ifdef ETH_TX_SCHED_PAD_EN
  logic [CW-1:0] w_cnt_after;
  assign w_cnt_after = w_room ? r_cnt + 1'b1 : r_cnt;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state    <= IDLE;
      r_gnt      <= '0;
      r_cnt      <= '0;
      r_drop     <= 1'b0;
      r_ifg      <= '0;
      r_byte     <= '0;
      r_byte_vld <= 1'b0;
      r_pkt_rdy  <= 1'b0;
      r_len_err  <= 1'b0;
    end else begin
      r_byte_vld <= 1'b0;
      r_pkt_rdy  <= 1'b0;
      r_len_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt  <= '0;
          r_drop <= 1'b0;
          if (w_arb_vld) begin
            r_gnt   <= w_arb_gnt;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          if (w_xfer) begin
            // Past the payload limit bytes are still consumed so the source can drain.
            if (w_room) begin
              r_byte     <= w_sel_byte;
              r_byte_vld <= 1'b1;
              r_cnt      <= r_cnt + 1'b1;
            end else if (!r_drop) begin
              r_drop    <= 1'b1;
              r_len_err <= 1'b1;
            end
            if (w_last) begin
`ifdef ETH_TX_SCHED_PAD_EN
              r_state <= (w_cnt_after < CW'(pMIN_PAYLOAD)) ? PAD : KICK;
`else
              r_state <= KICK;
`endif
            end
          end
        end
`ifdef ETH_TX_SCHED_PAD_EN
        PAD: begin
          r_byte     <= '0;
          r_byte_vld <= 1'b1;
          r_cnt      <= r_cnt + 1'b1;
          if (r_cnt == CW'(pMIN_PAYLOAD - 1)) r_state <= KICK;
        end
`endif
        KICK: begin
          r_pkt_rdy <= 1'b1;
          r_state   <= WAIT_TX;
        end
        WAIT_TX: if (Tx_En) r_state <= TX;
        TX: begin
          if (!Tx_En) begin
            r_ifg   <= IW'(pIFG_CYCLES - 1);
            r_state <= IFG;
          end
        end
        IFG: begin
          if (r_ifg == '0) begin
            r_gnt   <= '0;
            r_state <= IDLE;
          end else begin
            r_ifg <= r_ifg - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign Src_Ready      = (r_state == LOAD) ? r_gnt : '0;
  assign Src_Gnt        = r_gnt;
  assign Src_Done       = ((r_state == IFG) && (r_ifg == '0)) ? r_gnt : '0;
  assign Eth_Byte       = r_byte;
  assign Eth_Byte_Valid = r_byte_vld;
  assign Eth_Pkt_Rdy    = r_pkt_rdy;
  assign Busy           = (r_state != IDLE);
  assign Len_Err        = r_len_err;

endmodule

// File: doc/eth_tx_sched.md
Name: eth_tx_sched

Overview:
- Packet scheduler in front of the RMII transmit path.
- Shares the single transmitter between pNUM_SRC payload sources using round-robin arbitration.
- Streams the granted source's payload bytes into the transmitter's payload FIFO, then pulses the packet-ready strobe.
- Tracks the frame on the transmitter's Tx_En and enforces the inter-frame gap before the next grant.

Parameters:
- pNUM_SRC, 2: number of requesters (2..4).
- pMAX_PAYLOAD, 1500: max payload bytes forwarded per packet; must not exceed the tx FIFO depth.
- pIFG_CYCLES, 48: idle Clk cycles after Tx_En falls (96 bit times at 2 bits/clk).

Ports:
- Clk  in  1  RMII reference clock, 50 MHz.
- Rst  in  1  asynchronous, active-high reset.
- Src_Req  in  pNUM_SRC  per-source packet request; level, held until Src_Done.
- Src_Byte  in  8*pNUM_SRC  payload bytes; source i on bits [8i+7:8i].
- Src_Valid  in  pNUM_SRC  byte valid.
- Src_Last  in  pNUM_SRC  marks the final payload byte; qualified by Src_Valid.
- Src_Ready  out  pNUM_SRC  one-hot; the granted source may transfer.
- Src_Gnt  out  pNUM_SRC  one-hot grant, held from grant to Src_Done.
- Src_Done  out  pNUM_SRC  1-cycle pulse when the granted packet finishes the IFG.
- Eth_Byte  out  8  byte to the tx FIFO.
- Eth_Byte_Valid  out  1  tx FIFO write strobe.
- Eth_Pkt_Rdy  out  1  1-cycle pulse starting frame transmission.
- Tx_En  in  1  transmitter's Tx_En output, monitored.
- Busy  out  1  high in every state except IDLE.
- Len_Err  out  1  1-cycle pulse when payload bytes are dropped for exceeding pMAX_PAYLOAD.

Behaviour:
- Reset: every output is 0, the state is IDLE, the round-robin pointer is 0 and all counters are 0.
- IDLE:
  - If any Src_Req is set, the arbiter picks the first requester at or after the pointer, scanning upward with wrap.
  - Src_Gnt is registered and goes to LOAD on the next cycle.
  - The pointer becomes the winner + 1, modulo pNUM_SRC.
- LOAD:
  - Src_Ready[g] = 1.
  - A transfer occurs when Src_Valid[g] & Src_Ready[g].
  - Eth_Byte and Eth_Byte_Valid are registered: 1-cycle latency from the transfer.
  - An 11-bit byte counter increments on each forwarded byte.
  - At count == pMAX_PAYLOAD, further bytes are accepted but not written (Eth_Byte_Valid = 0), and Len_Err pulses once on the first dropped byte.
  - A transfer with Src_Last ends LOAD, then goes to PAD or KICK.
  - Src_Last on the very first byte is legal: payload of 1 byte.
- PAD: present only with the optional feature (see below).
- KICK:
  - Src_Ready = 0.
  - Eth_Pkt_Rdy = 1 for exactly one cycle, asserted after the last Eth_Byte_Valid cycle so that the FIFO holds all bytes.
  - Then go to WAIT_TX.
- WAIT_TX: wait for Tx_En = 1, then go to TX.
- TX: wait for Tx_En = 0, then go to IFG with the gap counter loaded to pIFG_CYCLES-1.
- IFG:
  - The counter decrements each cycle.
  - At 0: Src_Done[g] pulses, Src_Gnt clears, and the state returns to IDLE.
  - A new grant may be issued in the cycle after Src_Done.
- Requests:
  - Src_Req changes while the block is not in IDLE are ignored.
  - A grantee dropping Src_Req mid-LOAD has no effect; the packet completes only on Src_Last.
- Simultaneous requests are resolved purely by the pointer. With all sources requesting continuously, grants rotate 0,1,...,N-1,0.
- Asynchronous reset mid-packet forces IDLE immediately. Bytes already in the tx FIFO are the transmitter's responsibility, since the transmitter shares the same Rst.

Optional Feature:
- Macro: ETH_TX_SCHED_PAD_EN.
- Defined:
  - If the byte count after Src_Last is < 46, the block enters PAD.
  - PAD writes 0x00 bytes, one per cycle, until the count reaches 46, then goes to KICK.
  - Src_Ready = 0 during PAD.
- Undefined:
  - PAD does not exist; LOAD goes directly to KICK.
  - Short payloads are forwarded unpadded.

Decomposition:
- eth_tx_sched_pkg holds:
  - the typedef enum eth_tx_sched_state_t {IDLE, LOAD, PAD, KICK, WAIT_TX, TX, IFG};
  - the constants pMIN_PAYLOAD = 46 and pIFG_DEFAULT = 48.
- Sub-module rr_arbiter (parameter pNUM_SRC):
  - inputs: Clk, Rst, Req, Advance;
  - outputs: one-hot Gnt and Gnt_Valid;
  - owns the round-robin pointer.

Test Plan:
1. Rst released; Src_Req[0]=1 with 60 bytes 0x00..0x3B, Src_Last on 0x3B -> exactly 60 Eth_Byte_Valid cycles carrying 0x00..0x3B in order, then one Eth_Pkt_Rdy pulse; Src_Done[0] occurs 48 cycles after Tx_En falls.
2. Src_Req = 2'b11 held continuously for 4 packets -> Src_Gnt sequence is 01, 10, 01, 10, and the next grant never precedes the previous Src_Done.
3. Source sends 1600 bytes -> 1500 writes, a single Len_Err pulse at byte 1501, and one Eth_Pkt_Rdy.
4. With ETH_TX_SCHED_PAD_EN defined, a 10-byte payload -> 46 writes, the last 36 being 0x00. With it undefined -> 10 writes.
5. Src_Valid toggled 1-0-1 every cycle (backpressure gaps) -> no duplicated or lost bytes; Eth_Pkt_Rdy follows the last write.
6. Rst asserted during LOAD after 20 bytes -> all outputs 0 asynchronously; after release, a new request is granted to source 0.
